// File: rtl/axis_arb_pkg.sv
// Shared definitions for the two-input packet arbiter.
//   arb_state_e : arbiter FSM states
//   PORT0/PORT1 : requester indices, used for grant vector bit positions
package axis_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_GRANT0 = 2'd1,
    ARB_GRANT1 = 2'd2
  } arb_state_e;

  localparam int unsigned PORT0     = 0;
  localparam int unsigned PORT1     = 1;
  localparam int unsigned NUM_PORTS = 2;

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational 2-way round-robin picker.
//   req  in  2  request vector, bit n = requester n valid
//   prio in  1  requester favoured when both request
//   gnt  out 2  one-hot grant, 2'b00 when nothing requests
module axis_rr_pick
  import axis_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       prio,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt[PORT0] = 1'b1;
      2'b10:   gnt[PORT1] = 1'b1;
      2'b11:   gnt = prio ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream slave between
// two AXI-Stream masters. A grant is held from the first beat through the
// beat carrying tlast; while granted the stream passes through combinationally.
//   s00_axis_aclk / s00_axis_aresetn : clock, synchronous active-low reset
//   s00_axis_*  : requester 0 (tvalid, tready out, tlast, tdata, tstrb)
//   s01_axis_*  : requester 1 (same)
//   m00_axis_*  : shared output (tvalid out, tready in, tlast, tdata, tstrb)
//   m00_axis_tdest : source port of the current beat (AXIS_ARB_TDEST_EN only)
//   arb_grant   : one-hot active grant, 2'b00 while idle
// Optional feature macro: AXIS_ARB_TDEST_EN adds m00_axis_tdest.
module axis_pkt_arbiter #(
  parameter int C_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            s00_axis_aclk,
  input  logic                            s00_axis_aresetn,
  input  logic                            s00_axis_tvalid,
  output logic                            s00_axis_tready,
  input  logic                            s00_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                            s01_axis_tvalid,
  output logic                            s01_axis_tready,
  input  logic                            s01_axis_tlast,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s01_axis_tdata,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] s01_axis_tstrb,
  output logic                            m00_axis_tvalid,
  input  logic                            m00_axis_tready,
  output logic                            m00_axis_tlast,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
`ifdef AXIS_ARB_TDEST_EN
  output logic                            m00_axis_tdest,
`endif
  output logic [1:0]                      arb_grant
);

  import axis_arb_pkg::*;

  arb_state_e state_q, state_d;
  logic       prio_q, prio_d;
  logic [1:0] pick;

  axis_rr_pick u_pick (
    .req  ({s01_axis_tvalid, s00_axis_tvalid}),
    .prio (prio_q),
    .gnt  (pick)
  );

  always_ff @(posedge s00_axis_aclk) begin
    if (!s00_axis_aresetn) begin
      state_q <= ARB_IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    prio_d          = prio_q;
    s00_axis_tready = 1'b0;
    s01_axis_tready = 1'b0;
    m00_axis_tvalid = 1'b0;
    m00_axis_tlast  = 1'b0;
    m00_axis_tdata  = '0;
    m00_axis_tstrb  = '0;
    arb_grant       = 2'b00;
`ifdef AXIS_ARB_TDEST_EN
    m00_axis_tdest  = 1'b0;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        // Requests are only sampled here; a granted source must hold its beat.
        if (pick[PORT0]) begin
          state_d = ARB_GRANT0;
        end else if (pick[PORT1]) begin
          state_d = ARB_GRANT1;
        end
      end
      ARB_GRANT0: begin
        m00_axis_tvalid = s00_axis_tvalid;
        m00_axis_tlast  = s00_axis_tlast;
        m00_axis_tdata  = s00_axis_tdata;
        m00_axis_tstrb  = s00_axis_tstrb;
        s00_axis_tready = m00_axis_tready;
        arb_grant[PORT0] = 1'b1;
        if (s00_axis_tvalid && m00_axis_tready && s00_axis_tlast) begin
          state_d = ARB_IDLE;
          prio_d  = 1'b1;
        end
      end
      ARB_GRANT1: begin
        m00_axis_tvalid = s01_axis_tvalid;
        m00_axis_tlast  = s01_axis_tlast;
        m00_axis_tdata  = s01_axis_tdata;
        m00_axis_tstrb  = s01_axis_tstrb;
        s01_axis_tready = m00_axis_tready;
        arb_grant[PORT1] = 1'b1;
`ifdef AXIS_ARB_TDEST_EN
        m00_axis_tdest  = 1'b1;
`endif
        if (s01_axis_tvalid && m00_axis_tready && s01_axis_tlast) begin
          state_d = ARB_IDLE;
          prio_d  = 1'b0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Self-checking bench for axis_pkt_arbiter: directed scenarios plus random
// packet traffic, compared every cycle against a packet-level ownership model
// and a per-source beat scoreboard.
module tb_axis_pkt_arbiter;

  localparam int W  = 32;
  localparam int SW = W / 8;

  typedef struct {
    logic [W-1:0]  data;
    logic [SW-1:0] strb;
    logic          last;
    int            gap;
  } beat_t;

  logic          clk;
  logic          rstn;
  logic          src_valid [2];
  logic          src_last  [2];
  logic [W-1:0]  src_data  [2];
  logic [SW-1:0] src_strb  [2];
  logic          m00_ready;

  logic          s00_axis_tready, s01_axis_tready;
  logic          m00_axis_tvalid, m00_axis_tlast;
  logic [W-1:0]  m00_axis_tdata;
  logic [SW-1:0] m00_axis_tstrb;
  logic [1:0]    arb_grant;
`ifdef AXIS_ARB_TDEST_EN
  logic          m00_axis_tdest;
`endif

  axis_pkt_arbiter #(.C_AXIS_TDATA_WIDTH(W)) dut (
    .s00_axis_aclk    (clk),
    .s00_axis_aresetn (rstn),
    .s00_axis_tvalid  (src_valid[0]),
    .s00_axis_tready  (s00_axis_tready),
    .s00_axis_tlast   (src_last[0]),
    .s00_axis_tdata   (src_data[0]),
    .s00_axis_tstrb   (src_strb[0]),
    .s01_axis_tvalid  (src_valid[1]),
    .s01_axis_tready  (s01_axis_tready),
    .s01_axis_tlast   (src_last[1]),
    .s01_axis_tdata   (src_data[1]),
    .s01_axis_tstrb   (src_strb[1]),
    .m00_axis_tvalid  (m00_axis_tvalid),
    .m00_axis_tready  (m00_ready),
    .m00_axis_tlast   (m00_axis_tlast),
    .m00_axis_tdata   (m00_axis_tdata),
    .m00_axis_tstrb   (m00_axis_tstrb),
`ifdef AXIS_ARB_TDEST_EN
    .m00_axis_tdest   (m00_axis_tdest),
`endif
    .arb_grant        (arb_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;
  int ready_mode = 0;  // 0: always ready, 1: toggle, 2: random

  beat_t q  [2][$];    // beats still to be offered by each source
  beat_t sb [2][$];    // beats still expected on m00 from each source

  // Model: which source owns the output (-1 = nobody) and the tie-break favourite.
  int m_owner = -1;
  int m_prio  = 0;

  int glog[$];
  int blog_cyc[$];
  int blog_src[$];
  logic [W-1:0] blog_data[$];
  logic         blog_last[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compare + model + source drivers, one process.
  initial begin : engine
    bit    hs [2];
    bit    flush;
    beat_t b;
    flush = 1'b0;
    for (int n = 0; n < 2; n++) begin
      src_valid[n] = 1'b0; src_last[n] = 1'b0; src_data[n] = '0; src_strb[n] = '0;
    end
    m00_ready = 1'b1;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        int           o;
        logic         e_valid, e_last;
        logic [W-1:0] e_data;
        logic [SW-1:0] e_strb;
        o       = m_owner;
        e_valid = (o >= 0) ? src_valid[o] : 1'b0;
        e_last  = (o >= 0) ? src_last[o]  : 1'b0;
        e_data  = (o >= 0) ? src_data[o]  : '0;
        e_strb  = (o >= 0) ? src_strb[o]  : '0;
        check("m00_tvalid", m00_axis_tvalid, e_valid);
        check("m00_tlast",  m00_axis_tlast,  e_last);
        check("m00_tdata",  m00_axis_tdata,  e_data);
        check("m00_tstrb",  m00_axis_tstrb,  e_strb);
        check("s00_tready", s00_axis_tready, (o == 0) ? m00_ready : 1'b0);
        check("s01_tready", s01_axis_tready, (o == 1) ? m00_ready : 1'b0);
        check("arb_grant",  arb_grant, (o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00);
`ifdef AXIS_ARB_TDEST_EN
        check("m00_tdest",  m00_axis_tdest, (o == 1) ? 1'b1 : 1'b0);
`endif
        glog.push_back(int'(arb_grant));
        if (m00_axis_tvalid && m00_ready && o >= 0) begin
          blog_cyc.push_back(cyc);
          blog_src.push_back(o);
          blog_data.push_back(m00_axis_tdata);
          blog_last.push_back(m00_axis_tlast);
          if (sb[o].size() == 0) begin
            check("sb_unexpected_beat", 1, 0);
          end else begin
            b = sb[o].pop_front();
            check("sb_data", m00_axis_tdata, b.data);
            check("sb_strb", m00_axis_tstrb, b.strb);
            check("sb_last", m00_axis_tlast, b.last);
          end
        end
      end
      hs[0] = src_valid[0] && s00_axis_tready;
      hs[1] = src_valid[1] && s01_axis_tready;
      // Ownership rules: pick on request (favourite wins ties), release on tlast beat.
      if (!rstn) begin
        m_owner = -1;
        m_prio  = 0;
        flush   = 1'b1;
        sb[0].delete();
        sb[1].delete();
      end else if (m_owner < 0) begin
        if (src_valid[0] && src_valid[1]) m_owner = m_prio;
        else if (src_valid[0])            m_owner = 0;
        else if (src_valid[1])            m_owner = 1;
      end else if (src_valid[m_owner] && m00_ready && src_last[m_owner]) begin
        m_prio  = 1 - m_owner;
        m_owner = -1;
      end

      @(posedge clk);
      #1;
      for (int n = 0; n < 2; n++) begin
        if (flush) begin
          q[n].delete();
          src_valid[n] = 1'b0;
        end else begin
          if (hs[n]) begin
            void'(q[n].pop_front());
            src_valid[n] = 1'b0;
          end
          if (!src_valid[n] && q[n].size() > 0) begin
            b = q[n][0];
            if (b.gap > 0) begin
              b.gap--;
              q[n][0] = b;
            end else begin
              src_valid[n] = 1'b1;
              src_data[n]  = b.data;
              src_strb[n]  = b.strb;
              src_last[n]  = b.last;
            end
          end
        end
      end
      flush = 1'b0;
      case (ready_mode)
        0:       m00_ready = 1'b1;
        1:       m00_ready = ~m00_ready;
        default: m00_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    glog.delete(); blog_cyc.delete(); blog_src.delete();
    blog_data.delete(); blog_last.delete();
  endtask

  task automatic push_pkt(input int n, input int len, input logic [W-1:0] base,
                          input int gap_at, input int gap_len, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? W'($urandom) : base + W'(i);
      b.strb = rnd ? SW'($urandom) : '1;
      b.last = (i == len - 1);
      b.gap  = (i == gap_at) ? gap_len : (rnd ? $urandom_range(0, 2) : 0);
      q[n].push_back(b);
      sb[n].push_back(b);
    end
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((q[0].size() != 0 || q[1].size() != 0 || sb[0].size() != 0 ||
            sb[1].size() != 0 || m_owner >= 0) && k < 3000) begin
      tick();
      k++;
    end
    check("drain_within_budget", (k < 3000), 1);
    tick();
    tick();
  endtask

  initial begin : main
    int base;
    int exp_grant [10];
    int exp_src   [7];
    int exp_rel   [4];
    int k;
    rstn = 1'b0;
    tick();
    tick();
    chk_en = 1'b1;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("reset_grant",    arb_grant, 2'b00);
    check("reset_s00_rdy",  s00_axis_tready, 0);
    check("reset_s01_rdy",  s01_axis_tready, 0);
    check("reset_m00_vld",  m00_axis_tvalid, 0);
    check("reset_m00_data", m00_axis_tdata, 0);

    // Both sources valid from reset: 0, idle, 1, idle, 0.
    push_pkt(0, 3, 32'h0A00_0000, -1, 0, 1'b0);
    push_pkt(0, 3, 32'h0B00_0000, -1, 0, 1'b0);
    push_pkt(1, 3, 32'h1A00_0000, -1, 0, 1'b0);
    tick();
    clear_logs();
    drain();
    exp_grant = '{0, 1, 1, 1, 0, 2, 2, 2, 0, 1};
    for (int i = 0; i < 10; i++) check($sformatf("both_grant_%0d", i), glog[i], exp_grant[i]);
    check("both_pkt2_src", blog_src[3], 1);
    check("both_pkt3_src", blog_src[6], 0);
    check("both_pkt3_data", blog_data[6], 32'h0B00_0000);

    // Single 4-beat packet from s00, always ready: beats in cycles 1..4.
    push_pkt(0, 4, 32'hA000_0000, -1, 0, 1'b0);
    tick();
    clear_logs();
    base = cyc + 1;
    drain();
    check("p1_beats", blog_cyc.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("p1_cycle_%0d", i), blog_cyc[i] - base, i + 1);
      check($sformatf("p1_data_%0d", i), blog_data[i], 32'hA000_0000 + i);
      check($sformatf("p1_last_%0d", i), blog_last[i], (i == 3));
    end

    // s01 granted, drops tvalid 2 cycles mid-packet while s00 waits.
    push_pkt(1, 4, 32'hB000_0000, 2, 2, 1'b0);
    tick();
    clear_logs();
    base = cyc + 1;
    push_pkt(0, 3, 32'hC000_0000, -1, 0, 1'b0);
    drain();
    exp_src = '{1, 1, 1, 1, 0, 0, 0};
    exp_rel = '{1, 2, 5, 6};
    for (int i = 0; i < 7; i++) check($sformatf("hold_src_%0d", i), blog_src[i], exp_src[i]);
    for (int i = 0; i < 4; i++) check($sformatf("hold_cyc_%0d", i), blog_cyc[i] - base, exp_rel[i]);

    // tready toggling: beats accepted every other cycle, none lost or doubled.
    ready_mode = 1;
    push_pkt(0, 4, 32'hD000_0000, -1, 0, 1'b0);
    clear_logs();
    drain();
    ready_mode = 0;
    check("tog_beats", blog_cyc.size(), 4);
    for (int i = 0; i < 3; i++) check($sformatf("tog_gap_%0d", i), blog_cyc[i+1] - blog_cyc[i], 2);
    for (int i = 0; i < 4; i++) check($sformatf("tog_data_%0d", i), blog_data[i], 32'hD000_0000 + i);
    tick();

    // Reset after beat 2 of a 5-beat s01 packet.
    push_pkt(1, 5, 32'hE000_0000, -1, 0, 1'b0);
    clear_logs();
    k = 0;
    while (blog_cyc.size() < 2 && k < 50) begin
      tick();
      k++;
    end
    check("rst_wait_budget", (k < 50), 1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    #1;
    check("rst_mid_grant",   arb_grant, 2'b00);
    check("rst_mid_s00_rdy", s00_axis_tready, 0);
    check("rst_mid_s01_rdy", s01_axis_tready, 0);
    check("rst_mid_m00_vld", m00_axis_tvalid, 0);
    tick();
    push_pkt(0, 2, 32'hF000_0000, -1, 0, 1'b0);
    push_pkt(1, 2, 32'hF100_0000, -1, 0, 1'b0);
    clear_logs();
    drain();
    k = 0;
    while (k < glog.size() - 1 && glog[k] == 0) k++;
    check("rst_first_grant", glog[k], 1);
    check("rst_first_src",   blog_src[0], 0);

    // Random traffic.
    ready_mode = 2;
    for (int t = 0; t < 1500; t++) begin
      for (int n = 0; n < 2; n++) begin
        if (q[n].size() < 6 && $urandom_range(0, 3) == 0)
          push_pkt(n, $urandom_range(1, 6), '0, -1, 0, 1'b1);
      end
      tick();
    end
    drain();
    ready_mode = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Two-input, packet-granular round-robin arbiter that shares one AXI-Stream slave (the AES core input, or the stream checker in the no-VIP bench) between two AXI-Stream masters. It locks a grant for a whole packet, from the first accepted beat through the beat carrying tlast, so packets from different requesters never interleave. While a grant is active, data and handshake pass through combinationally. The block sits between the DMA/command sources and the `s00_axis_*` port of the downstream slave.

## Interface
- C_AXIS_TDATA_WIDTH, 32, data width of all three streams; must be a multiple of 8.
- s00_axis_aclk  in  1  single clock for all ports.
- s00_axis_aresetn  in  1  reset; one clock; reset is synchronous and active-low.
- s00_axis_tvalid / s00_axis_tready (out) / s00_axis_tlast  1 each  requester 0 handshake.
- s00_axis_tdata  in  C_AXIS_TDATA_WIDTH  requester 0 data.
- s00_axis_tstrb  in  C_AXIS_TDATA_WIDTH/8  requester 0 byte strobes.
- s01_axis_tvalid / s01_axis_tready (out) / s01_axis_tlast / s01_axis_tdata / s01_axis_tstrb  same widths  requester 1.
- m00_axis_tvalid (out) / m00_axis_tready (in) / m00_axis_tlast (out)  1 each  shared output handshake.
- m00_axis_tdata  out  C_AXIS_TDATA_WIDTH  shared output data.
- m00_axis_tstrb  out  C_AXIS_TDATA_WIDTH/8  shared output strobes.
- m00_axis_tdest  out  1  source port of the current beat; present only with AXIS_ARB_TDEST_EN.
- arb_grant  out  2  one-hot active grant; 2'b00 when IDLE.

## Operation
- FSM states: IDLE, GRANT0, GRANT1. Register `prio` selects the favoured port on a tie.
- IDLE:
  - Only s00 valid: next state GRANT0.
  - Only s01 valid: next state GRANT1.
  - Both valid: go to the GRANT of the port selected by `prio`.
  - Neither valid: stay in IDLE.
  - All treadys are 0 and m00_axis_tvalid is 0.
- GRANTn:
  - m00_axis_{tvalid,tdata,tstrb,tlast} = sNn_axis_*.
  - sNn_axis_tready = m00_axis_tready.
  - The other port's tready is 0.
- A beat transfers when m00_axis_tvalid && m00_axis_tready.
- On a transferred beat with tlast=1:
  - Next state is IDLE.
  - `prio` is set to the other port (1-n).
- Beats with tlast=0 keep the grant, including when tvalid drops mid-packet. There is no timeout and no pre-emption.
- Zero-length packets do not exist; every packet has at least one beat, and that beat carries tlast.
- Data, strobes and tlast are never modified, reordered or dropped.

## Timing
- Reset values: state IDLE, `prio` = 0, s00/s01 tready 0, m00_axis_tvalid 0, arb_grant 2'b00. m00 data, tstrb and tlast are 0 while IDLE.
- Arbitration latency:
  - The first beat of a packet can transfer at the earliest 1 cycle after tvalid is seen in IDLE.
  - Exactly one IDLE cycle separates consecutive packets.
- In GRANT, throughput is 1 beat/cycle and latency is zero (combinational path).
- A single-beat packet occupies 1 GRANT cycle plus 1 IDLE cycle.
- Both sources continuously valid: packets alternate 0,1,0,1…
- Reset asserted mid-packet: the next cycle is IDLE with `prio` = 0. The partial packet is abandoned, and the downstream slave sees a truncated packet (reset is global, so this is acceptable).
- A requester must hold tvalid and its data stable until the beat is accepted (AXI rule). The arbiter relies on this and samples only in IDLE.

## Configuration
- AXIS_ARB_TDEST_EN:
  - Defined: m00_axis_tdest exists. It is 0 in IDLE and GRANT0 and 1 in GRANT1, combinational alongside tdata.
  - Undefined: the port and its logic are absent. Behaviour is otherwise identical.

## Structure
- The shared package (`aes.vh` include or `axis_arb_pkg`) holds:
  - a typedef enum for the states {ARB_IDLE, ARB_GRANT0, ARB_GRANT1};
  - localparams for the port indices.
- One natural sub-module, `axis_rr_pick`: combinational 2-way round-robin picker taking (req[1:0], prio) and producing a one-hot grant. The remaining logic is FSM plus mux.

## Test plan
- Only s00 sends a 4-beat packet A0..A3, m00_axis_tready=1 -> beats appear on m00 in cycles 1–4 after tvalid rises, tlast on A3, s01_axis_tready stays 0 throughout.
- Both sources present 3-beat packets from reset -> order is port 0 packet, 1 IDLE cycle, port 1 packet, then port 0 again. arb_grant sequence is 01, 00, 10, 00, 01.
- s01 granted and drops tvalid for 2 cycles mid-packet while s00 is valid -> grant stays on s01, no s00 beat transfers until s01's tlast.
- m00_axis_tready toggles 1,0,1,0 during a 4-beat packet -> each beat is held until accepted, no duplication or loss, and the checker compares word-by-word against the expected queue.
- s00_axis_aresetn pulled low for 1 cycle after beat 2 of a 5-beat s01 packet -> the next cycle has all treadys 0 and arb_grant 00. A subsequent simultaneous request is granted to s00.
- With AXIS_ARB_TDEST_EN, interleaved packets from both ports -> m00_axis_tdest matches the source port on every beat. Without the macro, the build elaborates with the port absent.
